// File: rtl/axi_lite_slave_wr.sv
// AXI-Lite style write-only slave: independent AW/W capture, one-cycle register
// write, held B response, and a debug read-back port into the register file.
module axi_lite_slave_wr #(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        awvalid,
  input  logic [31:0]                 awaddr,
  output logic                        awready,
  input  logic                        wvalid,
  input  logic [31:0]                 wdata,
  output logic                        wready,
  output logic                        bvalid,
  output logic [1:0]                  bstatus,
  input  logic                        bready,
  input  logic [$clog2(NUM_REGS)-1:0] rd_idx,
  output logic [31:0]                 rd_data,
  output logic [15:0]                 wr_count
);

  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_W,
    WAIT_AW,
    WRITE,
    RESP
  } state_t;

  state_t state_q, state_n;

  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic aw_hs, w_hs, b_hs;
  logic aw_cap, w_cap;
  logic addr_err;
  logic wr_en;
  logic awready_n, wready_n, bvalid_n;
  logic [1:0] bstatus_n;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;

  // Misaligned or beyond the register file: any set bit above the index field.
  assign addr_err = (awaddr_q[1:0] != 2'b00) ||
                    (awaddr_q[ADDR_W-1:IDX_W+2] != '0);
  assign wr_en    = (state_q == WRITE) && !addr_err;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  // Next state, capture strobes and next values of the registered outputs
  always_comb begin
    state_n   = state_q;
    aw_cap    = 1'b0;
    w_cap     = 1'b0;
    bstatus_n = bstatus;
    case (state_q)
      IDLE: begin
        aw_cap = aw_hs;
        w_cap  = w_hs;
        if (aw_hs && w_hs) state_n = WRITE;
        else if (aw_hs)    state_n = WAIT_W;
        else if (w_hs)     state_n = WAIT_AW;
      end
      WAIT_W: begin
        w_cap = w_hs;
        if (w_hs) state_n = WRITE;
      end
      WAIT_AW: begin
        aw_cap = aw_hs;
        if (aw_hs) state_n = WRITE;
      end
      WRITE: begin
        bstatus_n = addr_err ? RESP_SLVERR : RESP_OKAY;
        state_n   = RESP;
      end
      RESP: begin
        if (b_hs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    awready_n = (state_n == IDLE) || (state_n == WAIT_AW);
    wready_n  = (state_n == IDLE) || (state_n == WAIT_W);
    bvalid_n  = (state_n == RESP);
  end

  // Handshake outputs and captured address/data
  always_ff @(posedge clk) begin
    if (reset) begin
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bstatus  <= RESP_OKAY;
      awaddr_q <= '0;
      wdata_q  <= '0;
    end else begin
      awready <= awready_n;
      wready  <= wready_n;
      bvalid  <= bvalid_n;
      bstatus <= bstatus_n;
      if (aw_cap) awaddr_q <= awaddr;
      if (w_cap)  wdata_q  <= wdata;
    end
  end

  // Register file and debug read-back
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) regs_q[awaddr_q[IDX_W+1:2]] <= wdata_q;
      rd_data <= regs_q[rd_idx];
    end
  end

  // Saturating count of accepted writes; only assigned when it moves
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count <= '0;
    end else if (wr_en && (wr_count != {CNT_W{1'b1}})) begin
      wr_count <= wr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_wr.sv
// Directed bench for axi_lite_slave_wr: ordering variants, SLVERR decode,
// response back-pressure, mid-transaction reset and counter saturation.
module tb_axi_lite_slave_wr;

  logic        clk = 1'b0;
  logic        reset;
  logic        awvalid;
  logic [31:0] awaddr;
  logic        awready;
  logic        wvalid;
  logic [31:0] wdata;
  logic        wready;
  logic        bvalid;
  logic [1:0]  bstatus;
  logic        bready;
  logic [3:0]  rd_idx;
  logic [31:0] rd_data;
  logic [15:0] wr_count;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_regs [16];
  logic [15:0] exp_cnt;

  axi_lite_slave_wr #(.NUM_REGS(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .awvalid  (awvalid),
    .awaddr   (awaddr),
    .awready  (awready),
    .wvalid   (wvalid),
    .wdata    (wdata),
    .wready   (wready),
    .bvalid   (bvalid),
    .bstatus  (bstatus),
    .bready   (bready),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input int idx, input string tag);
    rd_idx = 4'(idx);
    tick();
    check(tag, rd_data, exp_regs[idx]);
  endtask

  // mode 0: AW then W, 1: same cycle, 2: W then AW
  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                           input int mode, input logic [1:0] exp_st, input string tag);
    logic [31:0] a;
    a = addr;
    rd_idx = a[5:2];
    case (mode)
      0: begin
        awvalid = 1'b1; awaddr = addr; tick(); awvalid = 1'b0;
        check({tag, "_awready_lo"}, 32'(awready), 32'd0);
        check({tag, "_wready_hi"}, 32'(wready), 32'd1);
        wvalid = 1'b1; wdata = data; tick(); wvalid = 1'b0;
      end
      1: begin
        awvalid = 1'b1; awaddr = addr; wvalid = 1'b1; wdata = data;
        tick(); awvalid = 1'b0; wvalid = 1'b0;
      end
      default: begin
        wvalid = 1'b1; wdata = data; tick(); wvalid = 1'b0;
        check({tag, "_wready_lo"}, 32'(wready), 32'd0);
        check({tag, "_awready_hi"}, 32'(awready), 32'd1);
        awvalid = 1'b1; awaddr = addr; tick(); awvalid = 1'b0;
      end
    endcase
    check({tag, "_bvalid_write"}, 32'(bvalid), 32'd0);
    tick();
    check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
    check({tag, "_bstatus"}, 32'(bstatus), 32'(exp_st));
    if (exp_st == 2'b00) begin
      exp_regs[a[5:2]] = data;
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end
    bready = 1'b1; tick(); bready = 1'b0;
    check({tag, "_bvalid_done"}, 32'(bvalid), 32'd0);
    check({tag, "_readies"}, 32'({awready, wready}), 32'd3);
    check({tag, "_rd_data"}, rd_data, exp_regs[a[5:2]]);
    check({tag, "_wr_count"}, 32'(wr_count), 32'(exp_cnt));
  endtask

  initial begin
    reset = 1'b1; awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0;
    bready = 1'b0; rd_idx = '0;
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;
    exp_cnt = '0;
    repeat (3) tick();

    // Reset values
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_bstatus", 32'(bstatus), 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_readies", 32'({awready, wready}), 32'd3);

    // Ordering variants, all OKAY
    write_txn(32'h08, 32'hDEADBEEF, 0, 2'b00, "aw_then_w");
    write_txn(32'h3C, 32'h12345678, 1, 2'b00, "same_cycle");
    write_txn(32'h04, 32'hA5A50001, 2, 2'b00, "w_then_aw");

    // Out-of-range and misaligned addresses
    write_txn(32'h40, 32'hFFFFFFFF, 1, 2'b10, "err_range");
    write_txn(32'h06, 32'hFFFFFFFF, 0, 2'b10, "err_align");
    write_txn(32'h8000_0000, 32'hFFFFFFFF, 2, 2'b10, "err_high");
    for (int i = 0; i < 16; i++) check_reg(i, $sformatf("regfile_%0d", i));

    // Response back-pressure with a competing request
    awvalid = 1'b1; awaddr = 32'h10; wvalid = 1'b1; wdata = 32'hCAFE0004;
    tick();
    awaddr = 32'h14; wdata = 32'h0BAD0005;
    tick();
    exp_regs[4] = 32'hCAFE0004; exp_cnt = exp_cnt + 16'd1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_bvalid_%0d", i), 32'(bvalid), 32'd1);
      check($sformatf("stall_bstatus_%0d", i), 32'(bstatus), 32'd0);
      check($sformatf("stall_readies_%0d", i), 32'({awready, wready}), 32'd0);
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    tick();
    bready = 1'b0;
    check("stall_bvalid_done", 32'(bvalid), 32'd0);
    check("stall_readies_done", 32'({awready, wready}), 32'd3);
    check("stall_wr_count", 32'(wr_count), 32'(exp_cnt));
    check_reg(4, "stall_reg4");
    check_reg(5, "stall_reg5_ignored");

    // Reset while waiting for write data
    awvalid = 1'b1; awaddr = 32'h00; tick(); awvalid = 1'b0;
    check("ww_awready", 32'(awready), 32'd0);
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;
    exp_cnt = '0;
    tick();
    check("abort_readies", 32'({awready, wready}), 32'd3);
    check("abort_bvalid", 32'(bvalid), 32'd0);
    check("abort_wr_count", 32'(wr_count), 32'd0);
    check_reg(0, "abort_reg0");
    check_reg(2, "abort_reg2");
    check("abort_bvalid_late", 32'(bvalid), 32'd0);
    write_txn(32'h00, 32'h00000077, 2, 2'b00, "post_abort");

    // Saturation: preload the counter near its ceiling, then keep writing
    force dut.wr_count = 16'hFFFC;
    #1 release dut.wr_count;
    exp_cnt = 16'hFFFC;
    for (int i = 0; i < 5; i++)
      write_txn(32'h20, 32'h100 + 32'(i), 1, 2'b00, $sformatf("sat_%0d", i));
    write_txn(32'h44, 32'h0, 1, 2'b10, "sat_err");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
